// File: rtl/blink_pkg.sv
// Shared constants and FSM state type for the Blink cipher feeder/collector.
package blink_pkg;
  localparam int N          = 128;
  localparam int ROUND      = 16;
  localparam int WORD       = 32;
  localparam int CIPHER_LAT = 2;
  localparam int KEY_W      = N * ROUND / 2;
  localparam int KEY_WORDS  = 32;
  localparam int ADDR_W     = 6;
  localparam int ADDR_KEY   = 0;
  localparam int ADDR_TWK   = 32;
  localparam int ADDR_PT    = 36;
  localparam int ADDR_END   = 40;
  localparam int CNT_W      = $clog2(CIPHER_LAT + 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/blink_word_bank.sv
// Host-addressable 40x32 bank holding round keys, tweak and plaintext as wide
// registers; flags rejected writes and optionally increments the tweak.
module blink_word_bank
  import blink_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [WORD-1:0]   i_wr_data,
  input  logic              i_wr_allow,
  input  logic              i_twk_inc,
  output logic [KEY_W-1:0]  o_k0,
  output logic [N-1:0]      o_t,
  output logic [N-1:0]      o_p,
  output logic              o_wr_err
);
  logic [KEY_W-1:0] r_key;
  logic [N-1:0]     r_twk;
  logic [N-1:0]     r_pt;
  logic             r_wr_err;

  logic w_is_key, w_is_twk, w_is_pt, w_valid, w_we;
  logic [4:0] w_key_idx;
  logic [1:0] w_sub_idx;

  assign w_is_key  = (i_wr_addr <  ADDR_W'(ADDR_TWK));
  assign w_is_twk  = (i_wr_addr >= ADDR_W'(ADDR_TWK)) && (i_wr_addr < ADDR_W'(ADDR_PT));
  assign w_is_pt   = (i_wr_addr >= ADDR_W'(ADDR_PT))  && (i_wr_addr < ADDR_W'(ADDR_END));
  assign w_valid   = w_is_key || w_is_twk || w_is_pt;
  assign w_we      = i_wr_en && w_valid && i_wr_allow;
  assign w_key_idx = i_wr_addr[4:0];
  // Tweak (32..35) and plaintext (36..39) blocks are 4-aligned, so the low bits select the word.
  assign w_sub_idx = i_wr_addr[1:0];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_key    <= '0;
      r_twk    <= '0;
      r_pt     <= '0;
      r_wr_err <= 1'b0;
    end else begin
      r_wr_err <= i_wr_en && (!w_valid || !i_wr_allow);
      if (w_we && w_is_key) r_key[w_key_idx*WORD +: WORD] <= i_wr_data;
      if (w_we && w_is_twk) r_twk[w_sub_idx*WORD +: WORD] <= i_wr_data;
      else if (i_twk_inc)   r_twk <= r_twk + N'(1);
      if (w_we && w_is_pt)  r_pt[w_sub_idx*WORD +: WORD] <= i_wr_data;
    end
  end

  assign o_k0     = r_key;
  assign o_t      = r_twk;
  assign o_p      = r_pt;
  assign o_wr_err = r_wr_err;
endmodule

// File: rtl/blink_loader.sv
// Feeds the registered Blink cipher stage and collects its result over a
// valid/ready handshake. Optional tweak auto-increment: BLINK_TWEAK_INC_EN.
//   state | meaning
//   IDLE  | accepting writes and start
//   WAIT  | cipher pipeline in flight, writes rejected
//   DONE  | result held until consumer accepts
module blink_loader
  import blink_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [WORD-1:0]   i_wr_data,
  output logic              o_wr_err,
  input  logic              i_start,
  input  logic              i_enc,
  output logic              o_busy,
  output logic              o_res_valid,
  input  logic              i_res_ready,
  output logic [N-1:0]      o_res_data,
  output logic              o_cph_enc,
  output logic [KEY_W-1:0]  o_cph_K0,
  output logic [N-1:0]      o_cph_P,
  output logic [N-1:0]      o_cph_T,
  input  logic [N-1:0]      i_cph_C
);
  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_cph_enc;
  logic [N-1:0]     r_res_data;
  logic             w_accept, w_capture, w_twk_inc;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: if (i_start) begin
        w_accept    = 1'b1;
        w_cnt_nxt   = '0;
        w_state_nxt = WAIT;
      end
      WAIT: if (r_cnt == CNT_W'(CIPHER_LAT)) begin
        w_capture   = 1'b1;
        w_state_nxt = DONE;
      end else begin
        w_cnt_nxt   = r_cnt + CNT_W'(1);
      end
      DONE: if (i_res_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cph_enc  <= 1'b0;
      r_res_data <= '0;
    end else begin
      if (w_accept)  r_cph_enc  <= i_enc;
      if (w_capture) r_res_data <= i_cph_C;
    end
  end

`ifdef BLINK_TWEAK_INC_EN
  assign w_twk_inc = w_capture;
`else
  assign w_twk_inc = 1'b0;
`endif

  blink_word_bank u_bank (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_wr_en    (i_wr_en),
    .i_wr_addr  (i_wr_addr),
    .i_wr_data  (i_wr_data),
    .i_wr_allow (r_state != WAIT),
    .i_twk_inc  (w_twk_inc),
    .o_k0       (o_cph_K0),
    .o_t        (o_cph_T),
    .o_p        (o_cph_P),
    .o_wr_err   (o_wr_err)
  );

  assign o_busy      = (r_state == WAIT);
  assign o_res_valid = (r_state == DONE);
  assign o_res_data  = r_res_data;
  assign o_cph_enc   = r_cph_enc;
endmodule

// File: tb/tb_blink_loader.sv
// Directed bench for blink_loader with a 2-stage register cipher model
// C = enc ? (P^T^K0[127:0]) : ~(P^T^K0[127:0]).
module tb_blink_loader;
  logic          clk = 1'b0;
  logic          rst, wr_en, start, enc, res_ready;
  logic [5:0]    wr_addr;
  logic [31:0]   wr_data;
  logic          wr_err, busy, res_valid, cph_enc;
  logic [127:0]  res_data, cph_P, cph_T, cph_C, r_s1;
  logic [1023:0] cph_K0;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef BLINK_TWEAK_INC_EN
  localparam logic [127:0] INC = 128'd1;
`else
  localparam logic [127:0] INC = 128'd0;
`endif

  localparam logic [127:0] KLOW = {32'h3, 32'h2, 32'h1, 32'h0};
  localparam logic [127:0] KTOP = {32'h1F, 32'h1E, 32'h1D, 32'h1C};
  localparam logic [127:0] PA5  = {4{32'hA5A5A5A5}};
  localparam logic [127:0] PNEW = {{3{32'hA5A5A5A5}}, 32'hDEADBEEF};

  always #5 clk = ~clk;

  blink_loader dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_wr_en     (wr_en),
    .i_wr_addr   (wr_addr),
    .i_wr_data   (wr_data),
    .o_wr_err    (wr_err),
    .i_start     (start),
    .i_enc       (enc),
    .o_busy      (busy),
    .o_res_valid (res_valid),
    .i_res_ready (res_ready),
    .o_res_data  (res_data),
    .o_cph_enc   (cph_enc),
    .o_cph_K0    (cph_K0),
    .o_cph_P     (cph_P),
    .o_cph_T     (cph_T),
    .i_cph_C     (cph_C)
  );

  function automatic logic [127:0] model(input logic [127:0] p, input logic [127:0] t,
                                         input logic [127:0] k, input logic e);
    logic [127:0] x;
    x = p ^ t ^ k;
    return e ? x : ~x;
  endfunction

  always @(posedge clk) begin
    r_s1  <= model(cph_P, cph_T, cph_K0[127:0], cph_enc);
    cph_C <= r_s1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  logic [127:0] exp_t;

  initial begin
    rst = 1'b1; wr_en = 1'b0; start = 1'b0; enc = 1'b0; res_ready = 1'b0;
    wr_addr = '0; wr_data = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_busy",  busy, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_wrerr", wr_err, 0);
    chk("rst_data",  res_data, 0);
    chk("rst_P",     cph_P, 0);
    chk("rst_enc",   cph_enc, 0);
    chk("rst_K0",    |cph_K0, 0);

    // 1: load and encrypt
    for (int i = 0; i < 32; i++) wr(6'(i), 32'(i));
    wr(6'd32, 32'h1);
    for (int i = 33; i < 36; i++) wr(6'(i), 32'h0);
    for (int i = 36; i < 40; i++) wr(6'(i), 32'hA5A5A5A5);
    exp_t = 128'd1;
    chk("load_wrerr", wr_err, 0);
    chk("load_k0lo",  cph_K0[127:0], KLOW);
    chk("load_k0hi",  cph_K0[1023:896], KTOP);
    chk("load_T",     cph_T, exp_t);
    chk("load_P",     cph_P, PA5);

    start = 1'b1; enc = 1'b1;
    tick();
    start = 1'b0;
    chk("op1_busy0", busy, 1);
    chk("op1_enc",   cph_enc, 1);
    tick();
    chk("op1_busy1", busy, 1);
    chk("op1_rv1",   res_valid, 0);
    tick();
    chk("op1_rv2",   res_valid, 0);
    tick();
    chk("op1_rv3",   res_valid, 1);
    chk("op1_busy3", busy, 0);
    chk("op1_data",  res_data, model(PA5, exp_t, KLOW, 1'b1));

    // 2: backpressure then accept
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_rv",   res_valid, 1);
      chk("hold_data", res_data, model(PA5, exp_t, KLOW, 1'b1));
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("acc_rv", res_valid, 0);
    exp_t = exp_t + INC;

    // 3: write during WAIT rejected; bad address rejected
    start = 1'b1; enc = 1'b0;
    tick();
    start = 1'b0;
    chk("op2_busy", busy, 1);
    wr(6'd36, 32'h12345678);
    chk("wait_wrerr", wr_err, 1);
    chk("wait_P",     cph_P, PA5);
    tick();
    chk("wait_wrerr_end", wr_err, 0);
    tick();
    chk("op2_rv",   res_valid, 1);
    chk("op2_data", res_data, model(PA5, exp_t, KLOW, 1'b0));
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    exp_t = exp_t + INC;
    wr(6'd45, 32'hFFFFFFFF);
    chk("bad_wrerr", wr_err, 1);
    chk("bad_P",     cph_P, PA5);
    chk("bad_T",     cph_T, exp_t);
    chk("bad_k0",    cph_K0[127:0], KLOW);
    tick();
    chk("bad_wrerr_end", wr_err, 0);

    // 4: write + start same cycle; extra starts ignored
    wr_en = 1'b1; wr_addr = 6'd36; wr_data = 32'hDEADBEEF;
    start = 1'b1; enc = 1'b1;
    tick();
    wr_en = 1'b0;
    chk("op3_P", cph_P, PNEW);
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("op3_rv",   res_valid, 1);
    chk("op3_data", res_data, model(PNEW, exp_t, KLOW, 1'b1));
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("done_start_rv",   res_valid, 1);
    chk("done_start_busy", busy, 0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    exp_t = exp_t + INC;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("no2nd_rv",   res_valid, 0);
      chk("no2nd_busy", busy, 0);
    end

    // 5: reset mid-operation
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("op4_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_busy", busy, 0);
    chk("mrst_rv",   res_valid, 0);
    chk("mrst_K0",   |cph_K0, 0);
    chk("mrst_P",    cph_P, 0);
    chk("mrst_T",    cph_T, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("mrst_noresult", res_valid, 0);
    end

    // 6: tweak carry across word boundary
    wr(6'd32, 32'hFFFFFFFF);
    start = 1'b1; enc = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk("op5_rv",   res_valid, 1);
    chk("op5_data", res_data, 128'hFFFFFFFF);
    chk("op5_T",    cph_T, (INC != 0) ? 128'h1_0000_0000 : 128'hFFFFFFFF);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("op5_acc", res_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
